// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and bundles for the I/D memory arbiter.
// Build option MEM_ARB_RR_EN selects round-robin arbitration in mem_arbiter.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W       = 32;
    localparam int ARB_DATA_W       = 32;
    localparam int ARB_STARVE_LIMIT = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    typedef struct packed {
        logic i_win;
        logic d_win;
    } arb_pick_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick: combinational I/D winner select.
// MEM_ARB_RR_EN defined: round-robin; otherwise fixed D priority with starvation override.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic      i_req,
    input  logic      d_req,
    input  logic      starve_hit,
    input  arb_port_t rr_last,
    output arb_pick_t pick
);

`ifdef MEM_ARB_RR_EN
    logic unused_starve;
    assign unused_starve = starve_hit;

    always_comb begin
        pick = '0;
        if (i_req && d_req) begin
            pick.i_win = (rr_last == PORT_D);
            pick.d_win = (rr_last == PORT_I);
        end else begin
            pick.i_win = i_req;
            pick.d_win = d_req;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = rr_last;

    always_comb begin
        pick = '0;
        if (i_req && d_req) begin
            pick.i_win = starve_hit;
            pick.d_win = !starve_hit;
        end else begin
            pick.i_win = i_req;
            pick.d_win = d_req;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port cache between instruction fetch (I) and load/store (D).
// Build option MEM_ARB_RR_EN replaces fixed D priority with round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              cache_re_o,
    output logic              cache_we_o,
    output logic [ADDR_W-1:0] cache_raddr_o,
    output logic [ADDR_W-1:0] cache_waddr_o,
    output logic [DATA_W-1:0] cache_wdata_o,
    input  logic [DATA_W-1:0] cache_rdata_i
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_port_t         resp_port;
    arb_port_t         rr_last;
    arb_pick_t         pick;
    logic [DATA_W-1:0] resp_data;
    logic              starve_hit;
    logic              any_gnt;
    logic              d_rd_gnt;
    logic              d_wr_gnt;
    logic              resp_live;

    mem_arbiter_pick u_pick (
        .i_req      (i_req_i),
        .d_req      (d_req_i),
        .starve_hit (starve_hit),
        .rr_last    (rr_last),
        .pick       (pick)
    );

    // Grants are masked in reset so nothing reaches the cache then.
    assign i_gnt_o  = pick.i_win && !rst_i;
    assign d_gnt_o  = pick.d_win && !rst_i;
    assign any_gnt  = i_gnt_o || d_gnt_o;
    assign d_rd_gnt = d_gnt_o && !d_we_i;
    assign d_wr_gnt = d_gnt_o && d_we_i;

    assign cache_re_o    = i_gnt_o || d_rd_gnt;
    assign cache_we_o    = d_wr_gnt;
    assign cache_raddr_o = i_gnt_o  ? i_addr_i :
                           d_rd_gnt ? d_addr_i : '0;
    assign cache_waddr_o = d_wr_gnt ? d_addr_i : '0;
    assign cache_wdata_o = d_wr_gnt ? d_wdata_i : '0;

`ifndef MEM_ARB_RR_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk_i) begin
        if (rst_i || !i_req_i || i_gnt_o) begin
            starve_cnt <= '0;
        end else if (!starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_last <= PORT_D;
        end else if (i_gnt_o) begin
            rr_last <= PORT_I;
        end else if (d_gnt_o) begin
            rr_last <= PORT_D;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ARB_IDLE;
        unique case (state)
            ARB_IDLE: state_nxt = any_gnt ? ARB_RESP : ARB_IDLE;
            ARB_RESP: state_nxt = any_gnt ? ARB_RESP : ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Writes are acknowledged with zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_port <= PORT_D;
            resp_data <= '0;
        end else if (any_gnt) begin
            resp_port <= d_gnt_o ? PORT_D : PORT_I;
            resp_data <= d_wr_gnt ? '0 : cache_rdata_i;
        end
    end

    assign resp_live  = (state == ARB_RESP) && !rst_i;
    assign i_rvalid_o = resp_live && (resp_port == PORT_I);
    assign d_rvalid_o = resp_live && (resp_port == PORT_D);
    assign i_rdata_o  = i_rvalid_o ? resp_data : '0;
    assign d_rdata_o  = d_rvalid_o ? resp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus against a transaction-level model.
// Define MEM_ARB_RR_EN to check the round-robin build.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic          i_gnt_o;
    logic          i_rvalid_o;
    logic [DW-1:0] i_rdata_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o;
    logic          d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic          cache_re_o;
    logic          cache_we_o;
    logic [AW-1:0] cache_raddr_o;
    logic [AW-1:0] cache_waddr_o;
    logic [DW-1:0] cache_wdata_o;
    logic [DW-1:0] cache_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .i_req_i       (i_req_i),
        .i_addr_i      (i_addr_i),
        .i_gnt_o       (i_gnt_o),
        .i_rvalid_o    (i_rvalid_o),
        .i_rdata_o     (i_rdata_o),
        .d_req_i       (d_req_i),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_gnt_o       (d_gnt_o),
        .d_rvalid_o    (d_rvalid_o),
        .d_rdata_o     (d_rdata_o),
        .cache_re_o    (cache_re_o),
        .cache_we_o    (cache_we_o),
        .cache_raddr_o (cache_raddr_o),
        .cache_waddr_o (cache_waddr_o),
        .cache_wdata_o (cache_wdata_o),
        .cache_rdata_i (cache_rdata_i)
    );

    // Cache stand-in (written by the DUT's cache port) and the model's own memory.
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    assign cache_rdata_i = mem[cache_raddr_o[9:2]];

    int checks   = 0;
    int failures = 0;

    // Model state: I wait streak, last winner, pending response.
    int            i_waited;
    bit            last_d;
    bit            pend;
    bit            pend_d;
    logic [DW-1:0] pend_data;

    // Observed DUT outputs of the last step.
    bit            a_ig, a_dg, a_irv, a_drv;
    logic [DW-1:0] a_ird, a_drd;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(output bit ei, output bit ed);
        logic [AW-1:0] e_ra, e_wa, wa;
        logic [DW-1:0] e_wd, e_ird, e_drd, wd;
        bit            e_re, e_we, e_irv, e_drv, w;
        #1;
        ei = 1'b0;
        ed = 1'b0;
        if (!rst_i) begin
            if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
                if (last_d) ei = 1'b1;
                else        ed = 1'b1;
`else
                if (i_waited >= LIM) ei = 1'b1;
                else                 ed = 1'b1;
`endif
            end else if (i_req_i) begin
                ei = 1'b1;
            end else if (d_req_i) begin
                ed = 1'b1;
            end
        end
        e_re  = ei || (ed && !d_we_i);
        e_we  = ed && d_we_i;
        e_ra  = ei ? i_addr_i : ((ed && !d_we_i) ? d_addr_i : '0);
        e_wa  = (ed && d_we_i) ? d_addr_i : '0;
        e_wd  = (ed && d_we_i) ? d_wdata_i : '0;
        e_irv = !rst_i && pend && !pend_d;
        e_drv = !rst_i && pend && pend_d;
        e_ird = e_irv ? pend_data : '0;
        e_drd = e_drv ? pend_data : '0;

        chk("grant", {62'b0, i_gnt_o, d_gnt_o}, {62'b0, ei, ed});
        chk("cache_ctl", {62'b0, cache_re_o, cache_we_o}, {62'b0, e_re, e_we});
        chk("cache_addr", {cache_raddr_o, cache_waddr_o}, {e_ra, e_wa});
        chk("cache_wdata", {32'b0, cache_wdata_o}, {32'b0, e_wd});
        chk("i_resp", {31'b0, i_rvalid_o, i_rdata_o}, {31'b0, e_irv, e_ird});
        chk("d_resp", {31'b0, d_rvalid_o, d_rdata_o}, {31'b0, e_drv, e_drd});

        a_ig  = i_gnt_o;
        a_dg  = d_gnt_o;
        a_irv = i_rvalid_o;
        a_drv = d_rvalid_o;
        a_ird = i_rdata_o;
        a_drd = d_rdata_o;

        if (rst_i) begin
            pend     = 1'b0;
            i_waited = 0;
            last_d   = 1'b1;
        end else begin
            pend   = ei || ed;
            pend_d = ed;
            if (ei)                 pend_data = ref_mem[i_addr_i[9:2]];
            else if (ed && !d_we_i) pend_data = ref_mem[d_addr_i[9:2]];
            else                    pend_data = '0;
            if (ed && d_we_i) ref_mem[d_addr_i[9:2]] = d_wdata_i;
            if (i_req_i && !ei) i_waited = (i_waited < LIM) ? i_waited + 1 : LIM;
            else                i_waited = 0;
            if (ei) last_d = 1'b0;
            if (ed) last_d = 1'b1;
        end

        w  = cache_we_o;
        wa = cache_waddr_o;
        wd = cache_wdata_o;
        @(posedge clk_i);
        #1;
        if (w) mem[wa[9:2]] = wd;
        @(negedge clk_i);
    endtask

    initial begin
        bit         gi, gd;
        logic [9:0] pat;
        gi = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        i_waited  = 0;
        last_d    = 1'b1;
        pend      = 1'b0;
        pend_d    = 1'b0;
        pend_data = '0;
        rst_i     = 1'b1;
        i_req_i   = 1'b1;
        i_addr_i  = 32'h40;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h80;
        d_wdata_i = '0;
        @(negedge clk_i);

        // Reset with both requesting, then first grant.
        step(gi, gd);
        chk("t1_rst_gnt0", {62'b0, a_ig, a_dg}, 64'd0);
        step(gi, gd);
        chk("t1_rst_gnt1", {62'b0, a_ig, a_dg, a_irv, a_drv}, 64'd0);
        rst_i = 1'b0;
        step(gi, gd);
`ifdef MEM_ARB_RR_EN
        chk("t1_first", {62'b0, a_ig, a_dg}, 64'd2);
`else
        chk("t1_first", {62'b0, a_ig, a_dg}, 64'd1);
`endif
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        step(gi, gd);

        // I read alone.
        mem[8'h40]     = 32'hDEADBEEF;
        ref_mem[8'h40] = 32'hDEADBEEF;
        i_req_i  = 1'b1;
        i_addr_i = 32'h100;
        step(gi, gd);
        chk("t2_gnt", {63'b0, a_ig}, 64'd1);
        i_req_i = 1'b0;
        step(gi, gd);
        chk("t2_resp", {31'b0, a_irv, a_ird}, {31'b0, 1'b1, 32'hDEADBEEF});
        step(gi, gd);
        chk("t2_resp_once", {63'b0, a_irv}, 64'd0);

        // D write then read-back.
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h200;
        d_wdata_i = 32'h12345678;
        step(gi, gd);
        chk("t3_wr_gnt", {63'b0, a_dg}, 64'd1);
        d_we_i = 1'b0;
        step(gi, gd);
        chk("t3_rd_gnt_wack", {30'b0, a_dg, a_drv, a_drd}, {30'b0, 2'b11, 32'h0});
        d_req_i = 1'b0;
        step(gi, gd);
        chk("t3_rd_data", {31'b0, a_drv, a_drd}, {31'b0, 1'b1, 32'h12345678});

        // Both requesting continuously.
        i_req_i  = 1'b1;
        i_addr_i = 32'h104;
        d_req_i  = 1'b1;
        d_addr_i = 32'h204;
        for (int k = 0; k < 10; k++) begin
            step(gi, gd);
            pat[9-k] = a_dg;
        end
`ifdef MEM_ARB_RR_EN
        chk("t4_pattern", {54'b0, pat}, {54'b0, 10'b0101010101});
`else
        chk("t4_pattern", {54'b0, pat}, {54'b0, 10'b1111011110});
`endif
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        step(gi, gd);

        // Reset right after a D read grant drops the response.
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h208;
        step(gi, gd);
        chk("t6_gnt", {63'b0, a_dg}, 64'd1);
        d_req_i = 1'b0;
        rst_i   = 1'b1;
        step(gi, gd);
        chk("t6_rst_rvalid", {63'b0, a_drv}, 64'd0);
        rst_i = 1'b0;
        step(gi, gd);
        chk("t6_after_rvalid", {63'b0, a_drv}, 64'd0);

        // Random traffic with occasional resets.
        gi = 1'b0;
        gd = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_req_i || gi) begin
                i_req_i  = ($urandom_range(0, 99) < 60);
                i_addr_i = $urandom();
            end
            if (!d_req_i || gd) begin
                d_req_i   = ($urandom_range(0, 99) < 60);
                d_we_i    = $urandom_range(0, 1) == 1;
                d_addr_i  = $urandom();
                d_wdata_i = $urandom();
            end
            rst_i = ($urandom_range(0, 99) < 2);
            step(gi, gd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
